chip8_timer_ctrl: RTL

- Owns the CHIP-8 delay timer (DT) and sound timer (ST) registers.
- Decrements both on each `timer_60hz_tick` pulse from the `timer` block.
- Serves CPU read/write requests over a valid/ready interface.
- Drives a square-wave buzzer while ST is non-zero. Sits between the CPU core, the `timer` block and the audio pin.

---
 rtl/chip8_timer_pkg.sv | 16 +
 rtl/chip8_timer_ctrl_if.sv | 24 ++
 rtl/chip8_tone_gen.sv | 31 +++
 rtl/chip8_timer_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/chip8_timer_pkg.sv
// Shared constants and helpers for the CHIP-8 delay/sound timer controller.
package chip8_timer_pkg;

   localparam int TIMER_W = 8;

   localparam logic SEL_DT = 1'b0;
   localparam logic SEL_ST = 1'b1;

   // Buzzer half-period in clock cycles, floored at one so tiny clocks still toggle.
   function automatic int calc_half_period(input int clock_speed, input int tone_hz);
      int hp;
      hp = clock_speed / (2 * tone_hz);
      return (hp < 1) ? 1 : hp;
   endfunction

endpackage

// File: rtl/chip8_timer_ctrl_if.sv
// CPU-side valid/ready request and response channel of the timer controller.
interface chip8_timer_ctrl_if;
   import chip8_timer_pkg::*;

   logic               req_valid;
   logic               req_ready;
   logic               req_we;
   logic               req_sel;
   logic [TIMER_W-1:0] req_wdata;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [TIMER_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_sel, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_sel, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/chip8_tone_gen.sv
// Square-wave buzzer: toggles tone_out every HALF_PERIOD cycles while enabled.
module chip8_tone_gen #(
   parameter int HALF_PERIOD = 113
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic tone_out
);

   localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         tone_out <= 1'b0;
      end else if (!enable) begin
         cnt      <= '0;
         tone_out <= 1'b0;
      end else if (cnt == CNT_W'(HALF_PERIOD - 1)) begin
         cnt      <= '0;
         tone_out <= ~tone_out;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/chip8_timer_ctrl.sv
// CHIP-8 delay/sound timer registers with 60 Hz decrement, CPU access and buzzer.
module chip8_timer_ctrl
   import chip8_timer_pkg::*;
#(
   parameter int CLOCK_SPEED = 100000,
   parameter int TONE_HZ     = 440
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_60hz,
   input  logic               hold,
   chip8_timer_ctrl_if.slave  bus,
   output logic               sound_active,
   output logic               st_expired,
   output logic               tone_out
);

   localparam int HALF_PERIOD = calc_half_period(CLOCK_SPEED, TONE_HZ);

   typedef enum logic [1:0] {
      S_OFF,
      S_IDLE,
      S_RESP
   } state_t;

   state_t             state, state_nxt;
   logic [TIMER_W-1:0] dt, st, rdata_q;
   logic               accept, accept_rd, wr_dt, wr_st, dec;

   assign accept    = bus.req_valid & bus.req_ready;
   assign accept_rd = accept & ~bus.req_we;
   assign wr_dt     = accept & bus.req_we & (bus.req_sel == SEL_DT);
   assign wr_st     = accept & bus.req_we & (bus.req_sel == SEL_ST);
   assign dec       = tick_60hz & ~hold;

   assign bus.rsp_valid = (state == S_RESP);
   assign bus.rsp_rdata = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_OFF;
      else        state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      unique case (state)
         S_OFF:  state_nxt = S_IDLE;
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (accept_rd) state_nxt = S_RESP;
         end
         S_RESP: begin
            bus.req_ready = bus.rsp_ready;
            if (bus.rsp_ready && !accept_rd) state_nxt = S_IDLE;
         end
         default: state_nxt = S_OFF;
      endcase
   end

   // Reads capture the pre-update register value; responses hold until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         rdata_q <= '0;
      else if (accept_rd) rdata_q <= (bus.req_sel == SEL_ST) ? st : dt;
   end

   // A write on the same cycle as a tick wins and is not decremented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dt <= '0;
         st <= '0;
      end else begin
         if (wr_dt)                dt <= bus.req_wdata;
         else if (dec && dt != '0) dt <= dt - TIMER_W'(1);

         if (wr_st)                st <= bus.req_wdata;
         else if (dec && st != '0) st <= st - TIMER_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sound_active <= 1'b0;
         st_expired   <= 1'b0;
      end else begin
         sound_active <= (st != '0);
         st_expired   <= dec & ~wr_st & (st == TIMER_W'(1));
      end
   end

   chip8_tone_gen #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_tone_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (sound_active),
      .tone_out (tone_out)
   );

endmodule
